// File: rtl/alu_iter.sv
// alu_iter: small iterative ALU.
// Basic ops (op[4]=0) complete in one cycle. Extended ops (op[4]=1) are
// MUL (unsigned shift-add) and DIVU (unsigned restoring division). Each takes
// N iteration cycles and is only built when ALU_ITER_MULDIV_EN is defined.
// Without the macro every extended op is a 1-cycle op that clears y/y_hi and
// sets zero_q.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last result
// S_ITER | MUL/DIVU in progress, one operand bit per cycle
// S_DONE | done pulse; y/y_hi/flags were loaded on the edge into this state
module alu_iter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   op,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic [N-1:0] y_hi,
    output logic         carry_q,
    output logic         zero_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_y;
    logic [N-1:0] r_y_hi;
    logic         r_carry;
    logic         r_zero;
    logic [N:0]   w_r;
    logic         w_accept;
    logic         w_ext_iter;
    logic         w_last;

`ifdef ALU_ITER_MULDIV_EN
    localparam int CW = $clog2(N);

    // r_acc: partial product high word / partial remainder
    // r_mq : multiplier shifting out / dividend shifting out, quotient shifting in
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mq;
    logic [N-1:0]  r_mcand;
    logic          r_is_div;
    logic          r_div0;
    logic [CW-1:0] r_cnt;
    logic [N:0]    w_sum;
    logic [N:0]    w_shift;
    logic [N-1:0]  w_diff;
    logic [N-1:0]  w_acc_nxt;
    logic [N-1:0]  w_mq_nxt;

    assign w_ext_iter = op[4] && (op[3:1] == 3'b000);
    assign w_last     = (r_cnt == '0);
`else
    assign w_ext_iter = 1'b0;
    assign w_last     = 1'b1;
`endif

    assign w_accept = start && (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign y        = r_y;
    assign y_hi     = r_y_hi;
    assign carry_q  = r_carry;
    assign zero_q   = r_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_ext_iter ? S_ITER : S_DONE;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Basic-op result, one extra bit on top for the carry/borrow.
    always_comb begin
        w_r = '0;
        case (op[3:0])
            4'h0: w_r = '0;
            4'h1: w_r = {1'b0, a};
            4'h2: w_r = {1'b0, a} + {{N{1'b0}}, 1'b1};
            4'h3: w_r = {1'b0, a} - {{N{1'b0}}, 1'b1};
            4'h4: w_r = {a, 1'b0};
            4'h5: w_r = {a[0], 1'b0, a[N-1:1]};
            4'h6: w_r = {a, r_carry};
            4'h7: w_r = {a[0], r_carry, a[N-1:1]};
            4'h8: w_r = {1'b0, a | b};
            4'h9: w_r = {1'b0, a & b};
            4'hA: w_r = {1'b0, a ^ b};
            4'hB: w_r = {1'b0, b};
            4'hC: w_r = {1'b0, a} + {1'b0, b};
            4'hD: w_r = {1'b0, a} - {1'b0, b};
            4'hE: w_r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, r_carry};
            4'hF: w_r = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, r_carry};
            default: w_r = '0;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    // One MUL or DIVU step. The remainder is always below the divisor, so the
    // N-bit subtraction is exact whenever the trial succeeds.
    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, r_mcand};
        w_shift   = {r_acc, r_mq[N-1]};
        w_diff    = w_shift[N-1:0] - r_mcand;
        w_acc_nxt = r_acc;
        w_mq_nxt  = r_mq;
        if (r_is_div) begin
            if (w_shift >= {1'b0, r_mcand}) begin
                w_acc_nxt = w_diff;
                w_mq_nxt  = {r_mq[N-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift[N-1:0];
                w_mq_nxt  = {r_mq[N-2:0], 1'b0};
            end
        end else if (r_mq[0]) begin
            w_acc_nxt = w_sum[N:1];
            w_mq_nxt  = {w_sum[0], r_mq[N-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[N-1:1]};
            w_mq_nxt  = {r_acc[0], r_mq[N-1:1]};
        end
    end
`endif

    // Result/flag registers and iteration datapath; outputs change only on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y     <= '0;
            r_y_hi  <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
            r_acc    <= '0;
            r_mq     <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!op[4]) begin
                            r_y     <= w_r[N-1:0];
                            r_y_hi  <= '0;
                            r_carry <= w_r[N];
                            r_zero  <= (w_r[N-1:0] == '0);
                        end
`ifdef ALU_ITER_MULDIV_EN
                        else if (w_ext_iter) begin
                            r_acc    <= '0;
                            r_mq     <= a;
                            r_mcand  <= b;
                            r_is_div <= op[0];
                            r_div0   <= (b == '0);
                            r_cnt    <= CW'(N - 1);
                        end
`endif
                        else begin
                            r_y    <= '0;
                            r_y_hi <= '0;
                            r_zero <= 1'b1;
                        end
                    end
                end
`ifdef ALU_ITER_MULDIV_EN
                S_ITER: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_y    <= w_mq_nxt;
                        r_y_hi <= w_acc_nxt;
                        if (r_is_div) begin
                            r_carry <= r_div0;
                            r_zero  <= (w_mq_nxt == '0);
                        end else begin
                            r_carry <= (w_acc_nxt != '0);
                            r_zero  <= ({w_acc_nxt, w_mq_nxt} == '0);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (N=8). MUL/DIVU vectors are used when
// ALU_ITER_MULDIV_EN is defined; otherwise the 1-cycle extended-op behaviour is checked.
module tb_alu_iter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   op;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic [N-1:0] y_hi;
    logic         carry_q;
    logic         zero_q;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iter #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .op      (op),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .y       (y),
        .y_hi    (y_hi),
        .carry_q (carry_q),
        .zero_q  (zero_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 1-cycle op: start for one cycle, expect done on the next cycle, then return to idle.
    task automatic run_1cyc(input string tag, input logic [4:0] o, input logic [7:0] va,
                            input logic [7:0] vb, input logic [7:0] ey, input logic ec,
                            input logic ez);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done"},  done,    1);
        check({tag, " y"},     y,       ey);
        check({tag, " carry"}, carry_q, ec);
        check({tag, " zero"},  zero_q,  ez);
        @(negedge clk);
    endtask

`ifdef ALU_ITER_MULDIV_EN
    // Extended op with a bounded wait; lat is the start-to-done distance in cycles.
    task automatic run_ext(input logic [4:0] o, input logic [7:0] va, input logic [7:0] vb,
                           output int lat);
        @(negedge clk);
        op = o; a = va; b = vb; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 30);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst busy",  busy,    0);
        check("rst done",  done,    0);
        check("rst y",     y,       0);
        check("rst y_hi",  y_hi,    0);
        check("rst carry", carry_q, 0);
        check("rst zero",  zero_q,  0);

        // Carry-dependent ops rely on the carry left by the previous vector.
        run_1cyc("ADD",  5'h0C, 8'hFF, 8'h01, 8'h00, 1, 1);
        check("ADD y_hi", y_hi, 0);
        run_1cyc("ADC",  5'h0E, 8'h10, 8'h20, 8'h31, 0, 0);
        run_1cyc("SUB",  5'h0D, 8'h05, 8'h06, 8'hFF, 1, 0);
        run_1cyc("SBB",  5'h0F, 8'h05, 8'h01, 8'h03, 0, 0);
        run_1cyc("INC",  5'h02, 8'hFF, 8'h00, 8'h00, 1, 1);
        run_1cyc("ROL",  5'h06, 8'h80, 8'h00, 8'h01, 1, 0);
        run_1cyc("ROR",  5'h07, 8'h01, 8'h00, 8'h80, 1, 0);
        run_1cyc("LSR",  5'h05, 8'h81, 8'h00, 8'h40, 1, 0);
        run_1cyc("ASL",  5'h04, 8'hC0, 8'h00, 8'h80, 1, 0);
        run_1cyc("DEC",  5'h03, 8'h00, 8'h00, 8'hFF, 1, 0);
        run_1cyc("LDA",  5'h01, 8'h00, 8'h55, 8'h00, 0, 1);
        run_1cyc("XOR",  5'h0A, 8'hF0, 8'hFF, 8'h0F, 0, 0);
        run_1cyc("AND",  5'h09, 8'hF0, 8'h3C, 8'h30, 0, 0);
        run_1cyc("OR",   5'h08, 8'h0F, 8'h30, 8'h3F, 0, 0);
        run_1cyc("LDB",  5'h0B, 8'h12, 8'hA5, 8'hA5, 0, 0);
        run_1cyc("ZERO", 5'h00, 8'h12, 8'h34, 8'h00, 0, 1);

        // Start held into the DONE cycle must not launch a second op.
        @(negedge clk);
        op = 5'h0C; a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        op = 5'h0B; b = 8'h77;
        check("ign done", done, 1);
        check("ign y",    y,    8'h02);
        @(negedge clk);
        start = 1'b0;
        check("ign done2", done, 0);
        check("ign y2",    y,    8'h02);

        run_1cyc("ADD2", 5'h0C, 8'hFF, 8'h01, 8'h00, 1, 1);
`ifdef ALU_ITER_MULDIV_EN
        run_1cyc("EXT12", 5'h12, 8'h12, 8'h34, 8'h00, 1, 1);
        check("EXT12 y_hi", y_hi, 0);
        begin
            int lat;
            @(negedge clk);
            op = 5'h10; a = 8'hFF; b = 8'hFF; start = 1'b1;
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                start = (k == 3);
                if (k == 3) begin op = 5'h0C; a = 8'h01; b = 8'h01; end
                check($sformatf("MUL busy t+%0d", k), busy, 1);
                check($sformatf("MUL done t+%0d", k), done, (k == 9));
            end
            check("MUL y",     y,       8'h01);
            check("MUL y_hi",  y_hi,    8'hFE);
            check("MUL carry", carry_q, 1);
            check("MUL zero",  zero_q,  0);
            @(negedge clk);
            check("MUL idle", busy, 0);

            run_ext(5'h11, 8'h64, 8'h07, lat);
            check("DIV lat",   lat,     9);
            check("DIV y",     y,       8'h0E);
            check("DIV y_hi",  y_hi,    8'h02);
            check("DIV carry", carry_q, 0);
            run_ext(5'h11, 8'h2A, 8'h00, lat);
            check("DIV0 lat",   lat,     9);
            check("DIV0 y",     y,       8'hFF);
            check("DIV0 y_hi",  y_hi,    8'h2A);
            check("DIV0 carry", carry_q, 1);
            check("DIV0 zero",  zero_q,  0);
            @(negedge clk);
        end
        begin
            int seen;
            @(negedge clk);
            op = 5'h10; a = 8'h03; b = 8'h05; start = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                start = 1'b0;
            end
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("MRST busy",  busy,    0);
            check("MRST done",  done,    0);
            check("MRST y",     y,       0);
            check("MRST y_hi",  y_hi,    0);
            check("MRST carry", carry_q, 0);
            check("MRST zero",  zero_q,  0);
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("MRST no done", seen, 0);
        end
`else
        run_1cyc("EXT10", 5'h10, 8'h12, 8'h34, 8'h00, 1, 1);
        check("EXT10 y_hi", y_hi, 0);
        run_1cyc("SUB0",  5'h0D, 8'h05, 8'h05, 8'h00, 0, 1);
        run_1cyc("EXT1F", 5'h1F, 8'hAA, 8'h55, 8'h00, 0, 1);
`endif

        // Reset together with start: reset wins and the op is never launched.
        run_1cyc("LDA2", 5'h01, 8'h5A, 8'h00, 8'h5A, 0, 0);
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 5'h0C; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("RPRI busy",  busy,    0);
        check("RPRI done",  done,    0);
        check("RPRI y",     y,       0);
        check("RPRI carry", carry_q, 0);
        @(negedge clk);
        check("RPRI done2", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width, N >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port a, input, N bits: operand A, sampled on accepted start.
REQ-005 SHALL have port b, input, N bits: operand B, sampled on accepted start.
REQ-006 SHALL have port op, input, 5 bits: op[4]=0 selects a basic op (op[3:0]); op[4]=1 selects an extended op.
REQ-007 SHALL have port start, input, 1 bit: request; accepted only when busy=0.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when y/y_hi/flags are updated.
REQ-010 SHALL have port y, output, N bits: result low word.
REQ-011 SHALL have port y_hi, output, N bits: product high word or remainder; 0 for basic ops.
REQ-012 SHALL have port carry_q, output, 1 bit: registered carry flag.
REQ-013 SHALL have port zero_q, output, 1 bit: registered zero flag.

Function
REQ-014 SHALL implement states IDLE, ITER, DONE; IDLE->DONE on accepted basic op; IDLE->ITER on accepted extended op; ITER->DONE after exactly N iteration cycles; DONE->IDLE unconditionally.
REQ-015 SHALL assert done exactly in the DONE cycle; basic-op latency SHALL be 1 cycle (start at t, done at t+1); extended-op latency SHALL be N+1 cycles.
REQ-016 SHALL ignore start while busy=1, with no effect on operands, state or outputs.
REQ-017 SHALL compute basic ops as an (N+1)-bit result R: 0 ZERO=0; 1 LOAD_A={0,A}; 2 INC=A+1; 3 DEC=A-1; 4 ASL={A,0}; 5 LSR={A[0],0,A[N-1:1]}; 6 ROL={A,c}; 7 ROR={A[0],c,A[N-1:1]}; 8 OR, 9 AND, A XOR, B LOAD_B (all {0,result}); C ADD=A+B; D SUB=A-B; E ADC=A+B+c; F SBB=A-B-c; where c is the current carry_q.
REQ-018 SHALL, on basic-op completion, load y=R[N-1:0], y_hi=0, carry_q=R[N], zero_q=(R[N-1:0]==0).
REQ-019 SHALL implement extended op[3:0]=0 MUL as unsigned shift-add, one bit per cycle: {y_hi,y}=A*B; carry_q=(y_hi!=0); zero_q=(2N-bit product==0).
REQ-020 SHALL implement extended op[3:0]=1 DIVU as unsigned restoring division, one bit per cycle: y=A/B, y_hi=A%B, carry_q=0, zero_q=(y==0).
REQ-021 SHALL on DIVU with B=0 produce y=all ones, y_hi=A, carry_q=1, zero_q=0, still with N+1 latency.
REQ-022 SHALL treat extended op[3:0] values 2..15 as a 1-cycle op with y=0, y_hi=0, zero_q=1, carry_q unchanged.
REQ-023 SHALL hold y, y_hi, carry_q and zero_q stable between completions; intermediate iteration values SHALL NOT appear on the outputs.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, force state=IDLE, busy=0, done=0, y=0, y_hi=0, carry_q=0, zero_q=0, including mid-ITER (the operation is discarded).
REQ-025 SHALL give reset priority over a simultaneous start.

Configuration
REQ-026 SHALL, when macro ALU_ITER_MULDIV_EN is defined, implement REQ-019..REQ-021 and the ITER state.
REQ-027 SHALL, without ALU_ITER_MULDIV_EN, omit the ITER datapath and treat every op[4]=1 per REQ-022 (1-cycle, y=0, y_hi=0, zero_q=1, carry unchanged).

Verification
REQ-028 SHALL verify: N=8, ADD a=0xFF b=0x01 -> at t+1 done=1, y=0x00, carry_q=1, zero_q=1; then ADC a=0x10 b=0x20 -> y=0x31, carry_q=0.
REQ-029 SHALL verify: SUB a=0x05 b=0x06 -> y=0xFF, carry_q=1, zero_q=0; then SBB a=0x05 b=0x01 -> y=0x03.
REQ-030 SHALL verify (MULDIV_EN): MUL a=0xFF b=0xFF -> busy for cycles t+1..t+9, done at t+9, y=0x01, y_hi=0xFE, carry_q=1; start pulsed at t+3 is ignored.
REQ-031 SHALL verify (MULDIV_EN): DIVU a=0x64 b=0x07 -> y=0x0E, y_hi=0x02; DIVU a=0x2A b=0x00 -> y=0xFF, y_hi=0x2A, carry_q=1.
REQ-032 SHALL verify: reset asserted at t+4 of a MUL -> next cycle busy=0, done=0, all outputs 0; no done pulse follows.
REQ-033 SHALL verify (no MULDIV_EN): op=0x10 with a=0x12 b=0x34 -> done at t+1, y=0, y_hi=0, zero_q=1, carry_q unchanged.
